// File: rtl/mppt_sample_sequencer_if.sv
// mppt_sample_sequencer_if: ADC handshake and tracker publish/ack signals of the sample sequencer
interface mppt_sample_sequencer_if;
    logic        adc_start;
    logic        adc_ch;
    logic        adc_done;
    logic [15:0] adc_data;
    logic [15:0] v_avg;
    logic [15:0] i_avg;
    logic        sample_valid;
    logic        update_ack;

    modport master (
        output adc_start, adc_ch, v_avg, i_avg, sample_valid,
        input  adc_done, adc_data, update_ack
    );

    modport slave (
        input  adc_start, adc_ch, v_avg, i_avg, sample_valid,
        output adc_done, adc_data, update_ack
    );
endinterface

// File: rtl/mppt_sample_sequencer.sv
// mppt_sample_sequencer: interleaved V/I burst averaging over a shared ADC for the MPPT tracker
module mppt_sample_sequencer #(
    parameter int AVG_LOG2       = 2,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    mppt_sample_sequencer_if.master      bus,
    output logic                         timeout_err
);
    localparam int AW   = 16 + AVG_LOG2;
    localparam int IW   = AVG_LOG2 + 1;
    localparam int CMAX = SETTLE_CYCLES > TIMEOUT_CYCLES ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, PUBLISH, WAIT_ACK} state_t;

    state_t        state, next;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [AW-1:0] acc_v, acc_i, acc_i_sum;
    logic          done_ok, last, tmo;

    // Channel follows the conversion index parity; pulses are decoded from the state register
    assign bus.adc_start    = state == START;
    assign bus.sample_valid = state == PUBLISH;
    assign bus.adc_ch       = idx[0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // Next-state logic; done in the last allowed WAIT cycle beats the timeout
    always_comb begin
        done_ok   = state == WAIT && bus.adc_done;
        last      = &idx;
        tmo       = state == WAIT && !bus.adc_done && cnt == CW'(TIMEOUT_CYCLES - 1);
        acc_i_sum = acc_i + AW'(bus.adc_data);
        next      = state;
        case (state)
            IDLE:     next = en ? SETTLE : IDLE;
            SETTLE:   next = !en ? IDLE : cnt == '0 ? START : SETTLE;
            START:    next = WAIT;
            WAIT:     next = done_ok ? (last ? PUBLISH : START) : tmo ? (en ? SETTLE : IDLE) : WAIT;
            PUBLISH:  next = bus.update_ack ? SETTLE : WAIT_ACK;
            WAIT_ACK: next = bus.update_ack ? (en ? SETTLE : IDLE) : en ? WAIT_ACK : IDLE;
            default:  next = IDLE;
        endcase
    end

    // Shared counter: settle countdown, then per-conversion WAIT cycle count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                cnt <= '0;
        else if (next == SETTLE && state != SETTLE) cnt <= CW'(SETTLE_CYCLES - 1);
        else if (state == SETTLE)                  cnt <= cnt - CW'(1);
        else if (state == START)                   cnt <= '0;
        else if (state == WAIT)                    cnt <= cnt + CW'(1);
    end

    // Accumulators and sample index, cleared at the start of every burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_v <= '0;
            acc_i <= '0;
            idx   <= '0;
        end else if (state == SETTLE && next == START) begin
            acc_v <= '0;
            acc_i <= '0;
            idx   <= '0;
        end else if (done_ok) begin
            idx <= idx + IW'(1);
            if (idx[0]) acc_i <= acc_i_sum;
            else        acc_v <= acc_v + AW'(bus.adc_data);
        end
    end

    // Averages latch on the final current sample; timeout flag is sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.v_avg   <= '0;
            bus.i_avg   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (done_ok && last) begin
                bus.v_avg <= 16'(acc_v >> AVG_LOG2);
                bus.i_avg <= 16'(acc_i_sum >> AVG_LOG2);
            end
            if (tmo) timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mppt_sample_sequencer.sv
// tb_mppt_sample_sequencer: randomized scoreboard bench for the MPPT sample sequencer
module tb_mppt_sample_sequencer;
    localparam int L = 2;
    localparam int N = 1 << L;
    localparam int S = 4;
    localparam int T = 8;

    typedef struct {
        logic [15:0] v;
        logic [15:0] i;
    } pair_t;

    logic clk = 0;
    logic rst_n = 0;
    logic en = 0;
    logic timeout_err;

    mppt_sample_sequencer_if bus();

    mppt_sample_sequencer #(.AVG_LOG2(L), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .bus(bus.master),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    pair_t       exp_q[$];
    pair_t       e;
    int          checks = 0;
    int          failures = 0;
    int          fix_dly = 3;
    logic [15:0] v_s[N];
    logic [15:0] i_s[N];
    logic [15:0] last_v = 0;
    logic [15:0] last_i = 0;
    logic        prev_start = 0;
    logic        prev_valid = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the reference average whenever the DUT publishes
    always @(negedge clk) begin
        if (bus.sample_valid) begin
            if (exp_q.size() == 0) chk("unexpected_sample_valid", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("v_avg", bus.v_avg, e.v);
                chk("i_avg", bus.i_avg, e.i);
                last_v = e.v;
                last_i = e.i;
            end
            chk("valid_back_to_back", prev_valid, 0);
        end
        if (bus.adc_start) chk("start_back_to_back", prev_start, 0);
        prev_valid = bus.sample_valid;
        prev_start = bus.adc_start;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_start(output int n);
        n = 0;
        while (!bus.adc_start && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) begin
            v_s[k] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            i_s[k] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        end
    endtask

    // One burst acting as the ADC; expected pair pushed up front unless the burst is aborted
    task automatic burst(input int lat_exp, input int abort_at, input int drop_at);
        int n, d;
        longint sv, si;
        pair_t p;
        if (abort_at < 0) begin
            sv = 0;
            si = 0;
            for (int k = 0; k < N; k++) begin
                sv += v_s[k];
                si += i_s[k];
            end
            p.v = 16'(sv / N);
            p.i = 16'(si / N);
            exp_q.push_back(p);
        end
        for (int k = 0; k < 2 * N; k++) begin
            wait_start(n);
            if (k == 0) chk("first_start_latency", n, lat_exp);
            else        chk("conversion_spacing", n, 0);
            chk("adc_ch", bus.adc_ch, k % 2);
            if (k == drop_at) en = 0;
            if (k == abort_at) begin
                n = 0;
                while (!timeout_err && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("timeout_latency", n, T + 1);
                wait_start(n);
                chk("restart_after_timeout", n, S);
                chk("adc_ch_after_timeout", bus.adc_ch, 0);
                chk("v_avg_held", bus.v_avg, last_v);
                chk("i_avg_held", bus.i_avg, last_i);
                return;
            end
            d = fix_dly != 0 ? fix_dly : $urandom_range(2, T + 1);
            repeat (d - 1) @(negedge clk);
            bus.adc_done = 1;
            bus.adc_data = (k % 2) ? i_s[k / 2] : v_s[k / 2];
            @(negedge clk);
            bus.adc_done = 0;
            bus.adc_data = 16'($urandom);
        end
        chk("valid_after_last_done", bus.sample_valid, 1);
    endtask

    task automatic ack_measure();
        int n;
        bus.update_ack = 1;
        @(negedge clk);
        bus.update_ack = 0;
        n = 1;
        while (!bus.adc_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("start_after_ack", n, S + 1);
    endtask

    task automatic count_starts(input int cycles, output int c);
        c = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.adc_start) c++;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_adc_start"}, bus.adc_start, 0);
        chk({tag, "_adc_ch"}, bus.adc_ch, 0);
        chk({tag, "_v_avg"}, bus.v_avg, 0);
        chk({tag, "_i_avg"}, bus.i_avg, 0);
        chk({tag, "_sample_valid"}, bus.sample_valid, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        int n, c;
        bus.adc_done = 0;
        bus.adc_data = 0;
        bus.update_ack = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1;
        @(negedge clk);

        v_s = '{100, 102, 104, 106};
        i_s = '{50, 50, 50, 51};
        en = 1;
        burst(S + 1, -1, -1);
        count_starts(100, c);
        chk("no_start_without_ack", c, 0);
        ack_measure();

        v_s = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        i_s = '{1, 1, 1, 2};
        burst(0, -1, -1);
        ack_measure();

        fix_dly = T + 1;
        rand_data();
        burst(0, -1, -1);
        chk("done_on_last_wait_cycle_no_err", timeout_err, 0);
        ack_measure();

        fix_dly = 3;
        rand_data();
        burst(0, 2, -1);
        rand_data();
        burst(0, -1, -1);
        chk("timeout_sticky", timeout_err, 1);
        ack_measure();

        fix_dly = 0;
        repeat (6) begin
            rand_data();
            burst(0, -1, -1);
            repeat ($urandom_range(0, 10)) @(negedge clk);
            ack_measure();
        end

        rand_data();
        burst(0, -1, 3);
        repeat (3) @(negedge clk);
        bus.update_ack = 1;
        @(negedge clk);
        bus.update_ack = 0;
        count_starts(50, c);
        chk("no_start_after_disable", c, 0);

        en = 1;
        wait_start(n);
        chk("start_latency_reenable", n, S + 1);
        repeat (2) @(negedge clk);
        #1 rst_n = 0;
        #1 chk_zero("async_reset");
        last_v = 0;
        last_i = 0;
        en = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        bus.adc_done = 1;
        bus.adc_data = 16'h1234;
        @(negedge clk);
        bus.adc_done = 0;
        count_starts(20, c);
        chk("stale_done_no_start", c, 0);
        chk("stale_done_v_avg", bus.v_avg, 0);

        en = 1;
        fix_dly = 3;
        rand_data();
        burst(S + 1, -1, -1);
        en = 0;
        repeat (10) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mppt_sample_sequencer.md
# mppt_sample_sequencer

Acquisition controller that feeds the MPPT tracker. It shares a single ADC between the panel-voltage and panel-current channels, averages a burst of interleaved samples, and publishes one averaged (V, I) pair per tracking step. After publishing, it waits for the tracker to apply the new duty cycle, then waits a settle interval before the next burst. It sits between the ADC interface and the perturb-and-observe tracker, and sets the tracker's step rate.

## Interface
Parameters:
- AVG_LOG2, default 2: log2 of samples per channel per burst (N = 2^AVG_LOG2); range 0..4.
- SETTLE_CYCLES, default 1000: clock cycles waited before each burst; must be ≥1.
- TIMEOUT_CYCLES, default 255: maximum cycles spent waiting for one conversion; must be ≥1.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  tracking enable
- adc_start  out  1  one-cycle conversion request
- adc_ch  out  1  channel select: 0 = voltage, 1 = current; stable from adc_start until adc_done
- adc_done  in  1  one-cycle pulse; adc_data valid in the same cycle
- adc_data  in  16  unsigned conversion result
- v_avg  out  16  averaged voltage, unsigned
- i_avg  out  16  averaged current, unsigned
- sample_valid  out  1  one-cycle pulse; v_avg/i_avg hold new values during the pulse
- update_ack  in  1  tracker has applied the new duty cycle
- timeout_err  out  1  sticky ADC timeout flag

## Operation
- States:
  - IDLE
  - SETTLE
  - START: adc_start=1
  - WAIT: awaiting adc_done
  - PUBLISH: sample_valid=1
  - WAIT_ACK
- IDLE: en=1 → SETTLE, with settle counter loaded.
- SETTLE: lasts exactly SETTLE_CYCLES cycles. If en=0 in any SETTLE cycle → IDLE. On completion → START, with both accumulators and the sample index cleared.
- Burst: 2N conversions, strictly interleaved V,I,V,I,…
  - adc_ch = 0 for even conversions, 1 for odd.
  - START lasts one cycle, then WAIT.
- WAIT:
  - On adc_done, add adc_data to acc_v or acc_i, selected by adc_ch.
  - If more conversions remain → START. After the final I conversion → PUBLISH.
- Accumulators are 16+AVG_LOG2 bits wide and cannot overflow.
  - Average = acc >> AVG_LOG2 (truncating).
  - v_avg and i_avg are registered when the FSM enters PUBLISH.
- PUBLISH: one cycle, then WAIT_ACK.
  - An update_ack seen in the PUBLISH cycle is accepted and goes directly to SETTLE.
- WAIT_ACK:
  - update_ack=1 → SETTLE, or IDLE if en=0 in the same cycle.
  - en=0 without ack → IDLE.
- en is ignored in START and WAIT: a started burst always completes and publishes.
- Timeout: WAIT counts its cycles from 0.
  - If the TIMEOUT_CYCLES-th WAIT cycle passes without adc_done: set timeout_err, discard the burst (no publish, v_avg/i_avg unchanged), go to SETTLE (IDLE if en=0).
  - adc_done in that final cycle is accepted normally; done wins over timeout.
- timeout_err clears only on reset.
- Inputs outside their window are ignored:
  - adc_done outside WAIT
  - update_ack outside PUBLISH/WAIT_ACK
- Reset (asynchronous, any state, including mid-conversion): state IDLE. adc_start, adc_ch, v_avg, i_avg, sample_valid, timeout_err, accumulators and counters all 0. A conversion in flight is abandoned; its late adc_done falls in IDLE and is ignored.

## Timing
- All outputs are registered and Moore-decoded from state.
- adc_start and sample_valid are never high for two consecutive cycles.
- If en is sampled high in IDLE at edge t:
  - SETTLE occupies cycles t+1..t+SETTLE_CYCLES.
  - adc_start is high in cycle t+SETTLE_CYCLES+1.
- Conversion spacing: adc_done sampled at edge d → next adc_start is high in cycle d+1.
- Last adc_done at edge d → sample_valid is high in cycle d+1.
- Ack sampled at edge a → next adc_start is high in cycle a+SETTLE_CYCLES+1.
- A minimum burst (adc_done one cycle after each start) takes 2·2N cycles from the first adc_start to PUBLISH.

## Test plan
Use AVG_LOG2=2, SETTLE_CYCLES=4, TIMEOUT_CYCLES=8, and an ADC model with adc_done 3 cycles after adc_start unless stated otherwise.
- Nominal burst:
  - Stimulus: reset, en=1; V samples 100,102,104,106; I samples 50,50,50,51.
  - Response: adc_ch sequence 0,1,0,1,0,1,0,1; first adc_start 5 cycles after en is sampled; one sample_valid with v_avg=103, i_avg=50.
- Width/truncation:
  - Stimulus: all V samples 0xFFFF.
  - Response: v_avg=0xFFFF.
  - Stimulus: I samples 1,1,1,2.
  - Response: i_avg=1.
- Ack gating:
  - Stimulus: withhold update_ack for 100 cycles.
  - Response: no adc_start in that window.
  - Stimulus: assert ack at edge a.
  - Response: adc_start high in cycle a+5.
  - Stimulus: ack coincident with sample_valid.
  - Response: accepted; next adc_start 5 cycles later.
- Timeout:
  - Stimulus: suppress adc_done for the 3rd conversion.
  - Response: timeout_err rises after 8 WAIT cycles; no sample_valid; averages unchanged; new burst starts 5 cycles later with adc_ch=0; timeout_err stays 1 after a successful burst.
  - Stimulus: adc_done on the 8th WAIT cycle.
  - Response: accepted, no error.
- Enable drop:
  - Stimulus: en=0 mid-burst.
  - Response: burst completes, sample_valid fires, then IDLE; no further adc_start even after update_ack.
- Async reset:
  - Stimulus: rst_n low mid-WAIT.
  - Response: all outputs 0 immediately; stale adc_done ignored; normal burst resumes after en.
